k_instr_issue: RTL and testbench
================================

# k_instr_issue

Instruction issue sequencer that drives the operand-decode stage. It buffers operand pairs pushed by the control side and presents each one as a LOAD instruction word plus two loader operands, using a valid/ready handshake. When no operand pair is pending, it presents a NOP word (all zeros). It sits directly upstream of the decode logic and owns its `instruction`, `loader` and `loader1` inputs.

## Interface
- `DEPTH`, 4: operand-pair FIFO entries. Must be a power of two, at least 2.
- `OPCODE_LOAD`, 32'h1: instruction word presented with a valid operand pair.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `flush`  in  1  discard all buffered and presented pairs.
- `in_valid`  in  1  operand pair offered.
- `in_ready`  out  1  FIFO can accept a pair.
- `in_op_a`  in  32  operand for `rs1`.
- `in_op_b`  in  32  operand for `rs2`.
- `out_valid`  out  1  presented instruction is a live LOAD.
- `out_ready`  in  1  decode stage consumes the presented instruction.
- `instruction`  out  32  `OPCODE_LOAD` when `out_valid` is 1, otherwise 32'h0.
- `loader`  out  32  presented `op_a`; 0 when `out_valid` is 0.
- `loader1`  out  32  presented `op_b`; 0 when `out_valid` is 0.
- `count`  out  $clog2(DEPTH+1)  FIFO occupancy; the output register is not counted.

## Operation
- Storage is a circular FIFO of `DEPTH` {op_a, op_b} entries, with read and write pointers that wrap modulo `DEPTH`, followed by one output register (OREG).
- Push occurs when `in_valid & in_ready`.
- `in_ready = (count < DEPTH)`. It depends on registered `count` only, so a push is never accepted while the FIFO is full, even if a pop happens in the same cycle.
- Consume occurs when `out_valid & out_ready`.
- OREG load: when OREG is empty, or is being consumed this cycle, and `count > 0`, the FIFO head moves into OREG and the read pointer advances.
- State machine:
  - IDLE: OREG empty, `out_valid` = 0. Moves to ISSUE when `count > 0`.
  - ISSUE: OREG holds a pair, `out_valid` = 1.
    - Stays in ISSUE while stalled (`out_ready` = 0) or consumed with `count > 0`; a consume with `count > 0` refills OREG.
    - Moves to IDLE on a consume with `count == 0`.
- A simultaneous push and pop leaves `count` unchanged; both pointers advance.
- While `out_valid` is 0, the outputs `instruction`, `loader` and `loader1` are forced to 0. This makes the decode stage output `rs1 = rs2 = 0`.
- `flush`: at the next edge, `count`, both pointers and OREG clear and the state goes to IDLE. `flush` has priority over push, pop and consume in the same cycle.
- Reset has priority over `flush` and clears the same state. A reset mid-transfer discards all pending pairs. No partial output is left.

## Timing
- Reset values: `out_valid` = 0, `in_ready` = 1, `count` = 0, and `instruction`, `loader`, `loader1` all 0.
- Latency: a push at edge N into an empty block gives `out_valid` = 1 in the cycle after edge N+1, i.e. 2 cycles.
- Throughput: one instruction per cycle while `out_ready` = 1 and `count > 0`.
- Stall: while `out_ready` = 0, `instruction`, `loader` and `loader1` hold stable.
- Flush: the cycle after the flush edge shows `out_valid` = 0, `count` = 0 and `in_ready` = 1.

## Configuration
- `K_ISSUE_STATS_EN`
  - Defined: adds output `issued_cnt` [15:0].
    - It increments on each consume and wraps from 16'hFFFF to 0.
    - It is cleared by `rst` only; `flush` does not clear it.
  - Undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- Reset check: assert `rst` for 2 cycles, then release. Required: `out_valid` = 0, `instruction` = 0, `loader` = 0, `loader1` = 0, `count` = 0, `in_ready` = 1.
- Single issue latency: push {32'hA5A5_0001, 32'h0000_BEEF} at edge N with `out_ready` = 1. Required: in the cycle after edge N+1, `instruction` = 32'h1, `loader` = 32'hA5A5_0001, `loader1` = 32'h0000_BEEF. The following cycle returns `instruction` = 0.
- Stall: push 3 pairs with `out_ready` = 0 for 5 cycles, then raise `out_ready`.
  - Required during the stall: the first pair holds stable and `count` = 2.
  - Required after `out_ready` rises: the 3 pairs issue in order on consecutive cycles.
- Full and wrap-around: with `DEPTH` = 4, push 6 pairs while `out_ready` = 0.
  - Required while stalled: 5 pairs accepted (4 in the FIFO, 1 in OREG), `in_ready` = 0 once `count` = 4, and the 6th push is held.
  - Required after draining: all 6 pairs come out in order and the pointers wrap correctly.
- Flush mid-operation: with `count` = 3 and OREG valid, pulse `flush` together with `in_valid`. Required: the next cycle shows `count` = 0 and `out_valid` = 0, and the pushed pair is dropped.
- Stats (with `K_ISSUE_STATS_EN`): issue 5 pairs, then pulse `flush`. Required: `issued_cnt` = 5 and it stays 5 after the flush.

Source files
------------

// File: rtl/k_instr_issue.sv
`default_nettype none
// ============================================================================
// k_instr_issue : operand-pair FIFO plus output register that issues LOAD
//                 words (or an all-zero NOP) to the decode stage.
// Optional macro K_ISSUE_STATS_EN adds the issued_cnt consume counter.
// Revision      : 1.0
// ============================================================================

module k_instr_issue #(
    parameter int          DEPTH       = 4,
    parameter logic [31:0] OPCODE_LOAD = 32'h1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_op_a,
    input  logic [31:0]                in_op_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                instruction,
    output logic [31:0]                loader,
    output logic [31:0]                loader1,
`ifdef K_ISSUE_STATS_EN
    output logic [15:0]                issued_cnt,
`endif
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t             state_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic [31:0]        instr_q;
    logic [31:0]        loader_q;
    logic [31:0]        loader1_q;
    logic [63:0]        mem_q [DEPTH];

    logic               push_w;
    logic               consume_w;
    logic               pop_w;
    logic [63:0]        head_w;

    assign in_ready  = (count_q < C_DEPTH);
    assign out_valid = (state_q == S_ISSUE);
    assign push_w    = in_valid & in_ready;
    assign consume_w = out_valid & out_ready;
    // The FIFO head moves into OREG whenever OREG is free or being vacated.
    assign pop_w     = ((state_q == S_IDLE) | consume_w) & (count_q != '0);
    assign count_d   = count_q + CNT_W'(push_w) - CNT_W'(pop_w);
    assign head_w    = mem_q[rd_ptr_q];

    assign count       = count_q;
    assign instruction = instr_q;
    assign loader      = loader_q;
    assign loader1     = loader1_q;

    always_ff @(posedge clk) begin
        if (!rst && !flush && push_w) begin
            mem_q[wr_ptr_q] <= {in_op_a, in_op_b};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            instr_q   <= '0;
            loader_q  <= '0;
            loader1_q <= '0;
        end else begin
            if (push_w) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_w) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;

            case (state_q)
                S_IDLE: begin
                    if (pop_w) begin
                        state_q   <= S_ISSUE;
                        instr_q   <= OPCODE_LOAD;
                        loader_q  <= head_w[63:32];
                        loader1_q <= head_w[31:0];
                    end
                end
                S_ISSUE: begin
                    if (pop_w) begin
                        instr_q   <= OPCODE_LOAD;
                        loader_q  <= head_w[63:32];
                        loader1_q <= head_w[31:0];
                    end else if (consume_w) begin
                        state_q   <= S_IDLE;
                        instr_q   <= '0;
                        loader_q  <= '0;
                        loader1_q <= '0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef K_ISSUE_STATS_EN
    logic [15:0] issued_cnt_q;

    // Only reset clears the statistic; flush leaves it intact.
    always_ff @(posedge clk) begin
        if (rst) begin
            issued_cnt_q <= '0;
        end else if (consume_w) begin
            issued_cnt_q <= issued_cnt_q + 16'd1;
        end
    end

    assign issued_cnt = issued_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_k_instr_issue.sv
`default_nettype none
// ============================================================================
// tb_k_instr_issue : scoreboard bench for k_instr_issue (DEPTH = 4).
// Revision         : 1.0
// ============================================================================

module tb_k_instr_issue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_op_a = '0;
    logic [31:0] in_op_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] instruction;
    logic [31:0] loader;
    logic [31:0] loader1;
    logic [2:0]  count;
`ifdef K_ISSUE_STATS_EN
    logic [15:0] issued_cnt;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
    } pair_t;

    pair_t exp_q[$];
    pair_t mon_p;
    int    n_checks = 0;
    int    n_pass   = 0;

    always #5 clk = ~clk;

    k_instr_issue #(
        .DEPTH       (4),
        .OPCODE_LOAD (32'h1)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op_a     (in_op_a),
        .in_op_b     (in_op_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .instruction (instruction),
        .loader      (loader),
        .loader1     (loader1),
`ifdef K_ISSUE_STATS_EN
        .issued_cnt  (issued_cnt),
`endif
        .count       (count)
    );

    // Scoreboard monitor: every consumed word is compared against the queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                n_checks++;
                if (instruction !== 32'h1)
                    $display("FAIL mon_opcode: got %h want 00000001", instruction);
                else
                    n_pass++;
                if (out_ready) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL mon_unexpected: got %h/%h want nothing", loader, loader1);
                    end else begin
                        mon_p = exp_q.pop_front();
                        if ({loader, loader1} !== {mon_p.a, mon_p.b})
                            $display("FAIL mon_data: got %h/%h want %h/%h", loader, loader1, mon_p.a, mon_p.b);
                        else
                            n_pass++;
                    end
                end
            end else begin
                n_checks++;
                if ({instruction, loader, loader1} !== 96'h0)
                    $display("FAIL mon_nop: got %h/%h/%h want zeros", instruction, loader, loader1);
                else
                    n_pass++;
            end
        end
    end

    task automatic try_push(input logic [31:0] a, input logic [31:0] b,
                            input int maxcyc, output bit acc);
        acc      = 1'b0;
        in_valid = 1'b1;
        in_op_a  = a;
        in_op_b  = b;
        for (int i = 0; i < maxcyc && !acc; i++) begin
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (acc) exp_q.push_back(pair_t'{a: a, b: b});
    endtask

    task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
        bit acc;
        try_push(a, b, 50, acc);
        if (!acc) begin
            n_checks++;
            $display("FAIL push_timeout: got no accept want accept of %h", a);
        end
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !out_valid;
        end
        n_checks++;
        if (!done) $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++;
        if ({out_valid, in_ready, count} !== {1'b0, 1'b1, 3'd0})
            $display("FAIL reset_ctrl: got v=%b r=%b c=%0d want v=0 r=1 c=0", out_valid, in_ready, count);
        else n_pass++;
        n_checks++;
        if ({instruction, loader, loader1} !== 96'h0)
            $display("FAIL reset_data: got %h/%h/%h want zeros", instruction, loader, loader1);
        else n_pass++;
    endtask

    task automatic test_single_latency();
        out_ready = 1'b1;
        push_pair(32'hA5A5_0001, 32'h0000_BEEF);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL lat_early: got valid=%b want 0", out_valid);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({out_valid, instruction, loader, loader1} !== {1'b1, 32'h1, 32'hA5A5_0001, 32'h0000_BEEF})
            $display("FAIL lat_issue: got v=%b %h/%h/%h want v=1 00000001/a5a50001/0000beef",
                     out_valid, instruction, loader, loader1);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (instruction !== 32'h0) $display("FAIL lat_after: got %h want 0", instruction);
        else n_pass++;
        wait_drain();
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_pair(32'h5000_0000 + i, 32'h6000_0000 + i);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if ({out_valid, count, loader, loader1} !== {1'b1, 3'd2, 32'h5000_0000, 32'h6000_0000})
                $display("FAIL stall_hold: got v=%b c=%0d %h/%h want v=1 c=2 50000000/60000000",
                         out_valid, count, loader, loader1);
            else n_pass++;
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({out_valid, loader} !== {1'b1, 32'h5000_0000 + i})
                $display("FAIL stall_order: got v=%b %h want v=1 %h", out_valid, loader, 32'h5000_0000 + i);
            else n_pass++;
        end
        wait_drain();
    endtask

    task automatic test_full_wrap();
        bit acc;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_pair(32'h1000_0000 + i, 32'h2000_0000 + i);
        @(negedge clk);
        n_checks++;
        if ({count, in_ready, out_valid, loader} !== {3'd4, 1'b0, 1'b1, 32'h1000_0000})
            $display("FAIL full_state: got c=%0d r=%b v=%b %h want c=4 r=0 v=1 10000000",
                     count, in_ready, out_valid, loader);
        else n_pass++;
        try_push(32'h1000_0005, 32'h2000_0005, 3, acc);
        n_checks++;
        if (acc !== 1'b0) $display("FAIL full_hold: got accept=%b want 0", acc);
        else n_pass++;
        out_ready = 1'b1;
        try_push(32'h1000_0005, 32'h2000_0005, 10, acc);
        n_checks++;
        if (acc !== 1'b1) $display("FAIL full_retry: got accept=%b want 1", acc);
        else n_pass++;
        wait_drain();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_pair(32'h3000_0000 + i, 32'h4000_0000 + i);
        @(negedge clk);
        n_checks++;
        if ({count, out_valid} !== {3'd3, 1'b1})
            $display("FAIL flush_pre: got c=%0d v=%b want c=3 v=1", count, out_valid);
        else n_pass++;
        flush    = 1'b1;
        in_valid = 1'b1;
        in_op_a  = 32'hDEAD_0000;
        in_op_b  = 32'hDEAD_0001;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        n_checks++;
        if ({count, out_valid, in_ready, instruction} !== {3'd0, 1'b0, 1'b1, 32'h0})
            $display("FAIL flush_post: got c=%0d v=%b r=%b i=%h want c=0 v=0 r=1 i=0",
                     count, out_valid, in_ready, instruction);
        else n_pass++;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) $display("FAIL flush_drop: got v=%b want 0", out_valid);
            else n_pass++;
        end
    endtask

`ifdef K_ISSUE_STATS_EN
    task automatic test_stats();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) push_pair(32'h7000_0000 + i, 32'h8000_0000 + i);
        wait_drain();
        n_checks++;
        if (issued_cnt !== 16'd5) $display("FAIL stats_count: got %0d want 5", issued_cnt);
        else n_pass++;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        n_checks++;
        if (issued_cnt !== 16'd5) $display("FAIL stats_flush: got %0d want 5", issued_cnt);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_single_latency();
        test_stall();
        test_full_wrap();
        test_flush();
`ifdef K_ISSUE_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
